if_prefetch_stage: RTL and testbench
====================================

// Module: if_prefetch_stage
// PURPOSE
//  Next-generation instruction fetch stage for the 16-bit pipelined processor. Owns the fetch PC
//  and a FIFO_DEPTH-entry prefetch buffer. Talks to IM through a req/ack handshake that tolerates
//  wait states, and feeds ID through a valid/ready interface. Branch/jump redirect flushes the
//  buffer. Sits between IM and the ID stage, replacing the fixed single-cycle IF stage.
// PARAMETERS
//  DATA_WIDTH  16  instruction width
//  ADDR_WIDTH  8   PC / IM address width
//  FIFO_DEPTH  4   prefetch entries; power of 2, >=2
// PORTS
//  clk                   in   1           clock, rising edge
//  rst                   in   1           synchronous reset, active-high
//  start                 in   1           set processor status
//  stop                  in   1           clear processor status
//  PC_src_i              in   1           branch redirect (priority over jump_i)
//  branchAddr_i          in   ADDR_WIDTH  branch target
//  jump_i                in   1           jump redirect
//  jumpAddr_i            in   ADDR_WIDTH  jump target
//  im_req_o              out  1           IM fetch request
//  im_addr_o             out  ADDR_WIDTH  IM address (= fpc)
//  im_ack_i              in   1           IM completes request this cycle
//  im_data_i             in   DATA_WIDTH  instruction; valid with im_ack_i
//  id_valid_o            out  1           buffer head valid
//  id_instr_o            out  DATA_WIDTH  head instruction
//  id_pc_o               out  ADDR_WIDTH  head instruction address + 1
//  id_ready_i            in   1           ID consumes head
//  processor_status_r_o  out  1           running flag
//  PC                    out  ADDR_WIDTH  current fetch pointer fpc
//  fault_o               out  1           PC wrap fault (see CONFIGURATION)
// BEHAVIOUR
//  Reset: status=0, fpc=0, count=0, fault_o=0. id_valid_o=0. id_instr_o/id_pc_o read 0 whenever
//   id_valid_o=0. im_req_o is forced to 0 during any cycle with rst=1.
//  Status: next = (rst|stop) ? 0 : start ? 1 : hold. stop wins over start.
//  Request: im_req_o = status & (count<FIFO_DEPTH) & ~redirect & ~rst.
//   - A same-cycle pop does not free a slot for that cycle's request.
//   - im_addr_o = fpc and stays stable while im_req_o=1 and no ack has arrived.
//  Transaction: completes on the cycle where im_req_o & im_ack_i (zero-wait allowed).
//   - Push {im_data_i, fpc+1}; fpc <= fpc+1, wrapping mod 2^ADDR_WIDTH.
//   - im_ack_i with im_req_o=0 is ignored.
//  Output: FWFT buffer. Data acked in cycle N is visible at the head in cycle N+1 at the earliest.
//   - Pop on id_valid_o & id_ready_i; strict program order.
//   - Simultaneous push and pop leaves count unchanged.
//   - count never exceeds FIFO_DEPTH; pop on empty is a no-op.
//  Redirect (PC_src_i | jump_i): fpc <= PC_src_i ? branchAddr_i : jumpAddr_i.
//   - Buffer flushed: count=0 and id_valid_o=0 next cycle.
//   - im_req_o=0 in the redirect cycle, so no push occurs.
//   - Accepted regardless of status.
//  stop mid-stream: no new requests from the next cycle; buffered entries still drain to ID.
//   - A later start resumes from the held fpc.
//  rst mid-operation: buffer, fpc, status and fault all cleared at the next edge.
// CONFIGURATION
//  IF_PC_WRAP_CHK_EN defined:
//   - An acked fetch at fpc=all-ones pushes the entry, then sets fault_o (sticky), clears status
//     and holds fpc at all-ones instead of wrapping.
//   - start is ignored while fault_o=1; only rst clears fault_o.
//  IF_PC_WRAP_CHK_EN undefined: fpc wraps to 0; fault_o is tied to 0.
// TESTING
//  1 rst; start; im_ack_i=1, id_ready_i=1 -> im_addr_o 0,1,2,... one per cycle; id_pc_o 1,2,3,...
//    with each instruction one cycle after its ack.
//  2 id_ready_i=0, im_ack_i=1 -> exactly 4 pushes, then im_req_o=0. Raise ready -> 4 entries drain
//    one per cycle in order, then requests restart.
//  3 3 entries buffered; PC_src_i=1 (0x40) and jump_i=1 (0x80) in the same cycle -> id_valid_o=0
//    next cycle; next im_addr_o=0x40.
//  4 Ack delayed 3 cycles -> im_addr_o stable for all 4 req cycles; single push on ack.
//  5 stop with 2 entries buffered -> status=0 next cycle, im_req_o=0, both entries still delivered;
//    start -> fetching resumes at held fpc.
//  6 fpc=0xFF acked -> without macro next im_addr_o=0x00; with macro fault_o=1, status=0,
//    im_req_o=0, start ignored until rst.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a FIFO_DEPTH-entry first-word-fall-through
// prefetch buffer. IM is driven via req/ack (wait states tolerated); ID is
// fed via valid/ready. A branch/jump redirect flushes the buffer.
// Optional feature macro: IF_PC_WRAP_CHK_EN (sticky fault on fetch PC wrap).
module if_prefetch_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  PC_src_i,
  input  logic [ADDR_WIDTH-1:0] branchAddr_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
  output logic                  im_req_o,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  input  logic                  im_ack_i,
  input  logic [DATA_WIDTH-1:0] im_data_i,
  output logic                  id_valid_o,
  output logic [DATA_WIDTH-1:0] id_instr_o,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  input  logic                  id_ready_i,
  output logic                  processor_status_r_o,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  fault_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fpc;
  logic [PTR_W:0]          count;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0]   instr_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem    [FIFO_DEPTH];

  logic                    redirect;
  logic                    push;
  logic                    pop;
  logic                    wrap_hit;
  logic                    fault;
  logic [ADDR_WIDTH-1:0]   redirect_addr;

  assign redirect      = PC_src_i | jump_i;
  assign redirect_addr = PC_src_i ? branchAddr_i : jumpAddr_i;
  assign im_req_o      = (state_q == ST_RUN) & (count < DEPTH_CNT) & ~redirect & ~rst;
  assign im_addr_o     = fpc;
  assign push          = im_req_o & im_ack_i;
  assign id_valid_o    = (count != '0);
  assign pop           = id_valid_o & id_ready_i;
  assign wrap_hit      = push & (fpc == '1);

  assign processor_status_r_o = (state_q == ST_RUN);
  assign PC                   = fpc;
  assign id_instr_o           = id_valid_o ? instr_mem[rd_ptr] : '0;
  assign id_pc_o              = id_valid_o ? pc_mem[rd_ptr]    : '0;

`ifdef IF_PC_WRAP_CHK_EN
  logic fault_q;

  // Sticky wrap fault: set by an acked fetch at the top address, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)           fault_q <= 1'b0;
    else if (wrap_hit) fault_q <= 1'b1;
  end

  assign fault   = fault_q;
  assign fault_o = fault_q;
`else
  assign fault   = 1'b0;
  assign fault_o = 1'b0;
`endif

  // Running-flag state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Running-flag next state: stop (and a wrap fault) beat start; start is locked out while faulted
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
`ifdef IF_PC_WRAP_CHK_EN
    end else if (wrap_hit) begin
      state_d = ST_IDLE;
`endif
    end else if (start & ~fault) begin
      state_d = ST_RUN;
    end
  end

  // Fetch PC: redirect target, else advance on each completed IM transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= '0;
    end else if (redirect) begin
      fpc <= redirect_addr;
    end else if (push) begin
`ifdef IF_PC_WRAP_CHK_EN
      if (!wrap_hit) fpc <= fpc + 1'b1;
`else
      fpc <= fpc + 1'b1;
`endif
    end
  end

  // Buffer occupancy and pointers; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Buffer storage: fetched instruction with its sequential successor address
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= im_data_i;
      pc_mem[wr_ptr]    <= fpc + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed testbench for if_prefetch_stage. Inputs are driven 1 time unit
// after the rising edge and outputs are checked 2 units after it.
// IM returns {8'hA5, address} for every fetch.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic        PC_src_i, jump_i;
  logic [7:0]  branchAddr_i, jumpAddr_i;
  logic        im_req_o, im_ack_i;
  logic [7:0]  im_addr_o;
  logic [15:0] im_data_i;
  logic        id_valid_o, id_ready_i;
  logic [15:0] id_instr_o;
  logic [7:0]  id_pc_o;
  logic        processor_status_r_o, fault_o;
  logic [7:0]  PC;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign im_data_i = {8'hA5, im_addr_o};

  if_prefetch_stage #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .PC_src_i(PC_src_i), .branchAddr_i(branchAddr_i),
    .jump_i(jump_i), .jumpAddr_i(jumpAddr_i),
    .im_req_o(im_req_o), .im_addr_o(im_addr_o),
    .im_ack_i(im_ack_i), .im_data_i(im_data_i),
    .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
    .id_ready_i(id_ready_i),
    .processor_status_r_o(processor_status_r_o), .PC(PC), .fault_o(fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0;
    PC_src_i = 1'b0; jump_i = 1'b0; branchAddr_i = '0; jumpAddr_i = '0;
    im_ack_i = 1'b0; id_ready_i = 1'b0;

    // Reset (start asserted too; reset must win)
    repeat (2) cyc();
    #1;
    chk("req_in_rst", im_req_o, 0);
    chk("status_in_rst", processor_status_r_o, 0);
    rst = 1'b0; start = 1'b0;
    cyc(); #1;
    chk("rst_status", processor_status_r_o, 0);
    chk("rst_pc", PC, 0);
    chk("rst_valid", id_valid_o, 0);
    chk("rst_instr", id_instr_o, 0);
    chk("rst_idpc", id_pc_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_req", im_req_o, 0);

    // 1: streaming, zero-wait ack, ID always ready
    start = 1'b1; im_ack_i = 1'b1; id_ready_i = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("t1_status", processor_status_r_o, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t1_addr", im_addr_o, i);
      chk("t1_req", im_req_o, 1);
      if (i == 0) chk("t1_valid0", id_valid_o, 0);
      else begin
        chk("t1_valid", id_valid_o, 1);
        chk("t1_idpc", id_pc_o, i);
        chk("t1_instr", id_instr_o, 16'hA500 | (i - 1));
      end
      cyc(); #1;
    end

    // 2: fill with ID stalled, then drain
    jump_i = 1'b1; jumpAddr_i = 8'h10; #1;
    chk("t2_redir_req", im_req_o, 0);
    cyc(); jump_i = 1'b0; id_ready_i = 1'b0; #1;
    chk("t2_flush_valid", id_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_fill_addr", im_addr_o, 8'h10 + i);
      chk("t2_fill_req", im_req_o, 1);
      cyc(); #1;
    end
    chk("t2_full_req", im_req_o, 0);
    chk("t2_full_addr", im_addr_o, 8'h14);
    id_ready_i = 1'b1; #1;
    chk("t2_pop_no_free", im_req_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", id_valid_o, 1);
      chk("t2_drain_idpc", id_pc_o, 8'h11 + i);
      chk("t2_drain_instr", id_instr_o, 16'hA510 + i);
      cyc(); #1;
    end
    chk("t2_restart_idpc", id_pc_o, 8'h15);
    chk("t2_restart_instr", id_instr_o, 16'hA514);

    // 3: 3 buffered, branch and jump together -> branch wins, flush
    id_ready_i = 1'b0; jump_i = 1'b1; jumpAddr_i = 8'h20; #1;
    cyc(); jump_i = 1'b0; #1;
    repeat (3) cyc();
    #1;
    chk("t3_buf_valid", id_valid_o, 1);
    chk("t3_buf_idpc", id_pc_o, 8'h21);
    chk("t3_buf_addr", im_addr_o, 8'h23);
    im_ack_i = 1'b0; PC_src_i = 1'b1; branchAddr_i = 8'h40; jump_i = 1'b1; jumpAddr_i = 8'h80; #1;
    chk("t3_redir_req", im_req_o, 0);
    cyc(); PC_src_i = 1'b0; jump_i = 1'b0; #1;
    chk("t3_valid", id_valid_o, 0);
    chk("t3_instr", id_instr_o, 0);
    chk("t3_idpc", id_pc_o, 0);
    chk("t3_addr", im_addr_o, 8'h40);
    chk("t3_req", im_req_o, 1);

    // 4: ack after 3 wait states
    id_ready_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_wait_addr", im_addr_o, 8'h40);
      chk("t4_wait_req", im_req_o, 1);
      chk("t4_wait_valid", id_valid_o, 0);
      cyc(); #1;
    end
    im_ack_i = 1'b1; #1;
    chk("t4_ack_addr", im_addr_o, 8'h40);
    chk("t4_ack_req", im_req_o, 1);
    cyc(); im_ack_i = 1'b0; #1;
    chk("t4_valid", id_valid_o, 1);
    chk("t4_idpc", id_pc_o, 8'h41);
    chk("t4_instr", id_instr_o, 16'hA540);
    chk("t4_addr", im_addr_o, 8'h41);
    cyc(); #1;
    chk("t4_single_push", id_valid_o, 0);

    // 5: stop with 2 buffered, drain, resume
    id_ready_i = 1'b0; im_ack_i = 1'b1; #1;
    repeat (2) cyc();
    im_ack_i = 1'b0; stop = 1'b1; #1;
    cyc(); stop = 1'b0; #1;
    chk("t5_status", processor_status_r_o, 0);
    chk("t5_req", im_req_o, 0);
    chk("t5_valid", id_valid_o, 1);
    chk("t5_idpc0", id_pc_o, 8'h42);
    chk("t5_instr0", id_instr_o, 16'hA541);
    im_ack_i = 1'b1; id_ready_i = 1'b1; #1;
    chk("t5_req_ack", im_req_o, 0);
    cyc(); #1;
    chk("t5_idpc1", id_pc_o, 8'h43);
    chk("t5_instr1", id_instr_o, 16'hA542);
    cyc(); #1;
    chk("t5_empty", id_valid_o, 0);
    chk("t5_hold_addr", im_addr_o, 8'h43);
    chk("t5_hold_req", im_req_o, 0);
    im_ack_i = 1'b0; start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("t5_resume_status", processor_status_r_o, 1);
    chk("t5_resume_req", im_req_o, 1);
    chk("t5_resume_addr", im_addr_o, 8'h43);

    // 6: fetch at 0xFF
    id_ready_i = 1'b0; jump_i = 1'b1; jumpAddr_i = 8'hFF; #1;
    cyc(); jump_i = 1'b0; im_ack_i = 1'b1; #1;
    chk("t6_addr_ff", im_addr_o, 8'hFF);
    chk("t6_req_ff", im_req_o, 1);
    cyc(); im_ack_i = 1'b0; #1;
    chk("t6_valid", id_valid_o, 1);
    chk("t6_idpc", id_pc_o, 8'h00);
    chk("t6_instr", id_instr_o, 16'hA5FF);
`ifdef IF_PC_WRAP_CHK_EN
    chk("t6_fault", fault_o, 1);
    chk("t6_status", processor_status_r_o, 0);
    chk("t6_req", im_req_o, 0);
    chk("t6_pc_hold", PC, 8'hFF);
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("t6_start_ignored", processor_status_r_o, 0);
    chk("t6_req_after_start", im_req_o, 0);
    chk("t6_fault_sticky", fault_o, 1);
`else
    chk("t6_fault", fault_o, 0);
    chk("t6_wrap_addr", im_addr_o, 8'h00);
    chk("t6_wrap_req", im_req_o, 1);
`endif

    // 7: reset mid-operation
    id_ready_i = 1'b1; im_ack_i = 1'b1; rst = 1'b1; #1;
    chk("t7_req_in_rst", im_req_o, 0);
    cyc(); rst = 1'b0; im_ack_i = 1'b0; #1;
    chk("t7_status", processor_status_r_o, 0);
    chk("t7_pc", PC, 0);
    chk("t7_valid", id_valid_o, 0);
    chk("t7_fault", fault_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
